ble_buf_arbiter: RTL and testbench
==================================

// Module: ble_buf_arbiter
// PURPOSE
// - Shares the single-port BLE PHY packet buffer SRAM between the AHB data-slicer port and the PHY baseband port.
// - Sits between the slicer FIFO outputs, the baseband TX/RX engines and the SRAM macro.
// - Arbitrates one word access per cycle, replays AHB accesses that lose arbitration, and stalls AHB via ahb_stall (feeds hready low).
// PARAMETERS
// - AW     8   word address width (slicer AD-2)
// - CNT_W  16  width of saturating conflict counter
// PORTS
// - clk          in   1    clock
// - reset        in   1    asynchronous, active-low reset
// - ahb_wr_en    in   1    slicer word write request (data phase)
// - ahb_rd_en    in   1    slicer word read request (address phase)
// - ahb_addr     in   AW   slicer word address
// - ahb_wdata    in   32   slicer write data
// - ahb_rdata    out  32   read data to slicer
// - ahb_stall    out  1    1 = hold AHB data phase (drive hready low)
// - phy_req      in   1    baseband access request, held until phy_gnt
// - phy_we       in   1    1 = write, 0 = read
// - phy_addr     in   AW   baseband word address
// - phy_wdata    in   32   baseband write data
// - phy_prio     in   1    1 = PHY wins every fresh conflict (RX real-time mode)
// - phy_gnt      out  1    access issued this cycle
// - phy_rvalid   out  1    phy_rdata valid (cycle after read grant)
// - phy_rdata    out  32   read data to baseband
// - mem_en/mem_we out 1   SRAM enable / write enable
// - mem_addr     out  AW   SRAM address;  mem_wdata out 32 SRAM write data
// - mem_rdata    in   32   SRAM read data, 1-cycle synchronous latency
// - conflict_cnt out  CNT_W saturating count of AHB-loss events
// BEHAVIOUR
// - Reset: FSM=RUN, last_owner=AHB, pending cleared; mem_en/mem_we/phy_gnt/phy_rvalid/ahb_stall=0; rdata hold regs and conflict_cnt=0. Reset mid-access drops pending access silently.
// - AHB request = (ahb_wr_en|ahb_rd_en) & ~ahb_stall; wr_en has precedence if both high. Requests while ahb_stall=1 are ignored.
// - FSM RUN: only AHB -> AHB issued; only PHY -> PHY issued, phy_gnt=1 same cycle (combinational).
//   Both: winner = PHY if phy_prio, else the side != last_owner (round-robin). last_owner updates on every issue.
//   AHB loses -> latch addr/wdata/we into pending reg, conflict_cnt+1 (saturates at all-ones), next state REPLAY.
// - FSM REPLAY: pending AHB access issued unconditionally; phy_gnt=0; -> RUN. ahb_stall = (state==REPLAY), registered.
// - Therefore AHB worst-case stall = 1 cycle; PHY worst-case wait = 1 cycle (phy_prio=0) or 1 cycle after a replay (phy_prio=1).
// - Memory drive: exactly one of {AHB, PHY, pending} drives mem_* when mem_en=1; mem_we=0 on reads; idle -> mem_en=0, addr/wdata=0.
// - Read return: ahb_ret/phy_ret flags registered from read issue. ahb_rdata = ahb_ret ? mem_rdata : hold_q (hold_q captures on ahb_ret). phy_rvalid=phy_ret; phy_rdata = mem_rdata when phy_rvalid else 0.
// - Unreplayed AHB read: data returned in cycle N+1 with stall=0; replayed read: stall=1 in N+1, data valid N+2.
// - Writes: no return cycle; replayed write completes in REPLAY cycle, ahb_stall drops next cycle.
// - Same-address write/read in consecutive cycles: SRAM order = issue order (no bypass).
// - phy_req deasserted before grant: request withdrawn, no access; phy_we/addr/wdata must be stable while phy_req=1 and ungranted.
// TESTING
// - AHB read 0x12 alone, mem holds 0xDEADBEEF -> mem_en=1,we=0 at N; ahb_rdata=0xDEADBEEF at N+1, ahb_stall=0 throughout.
// - AHB write 0x05 + PHY read 0x07 same cycle, phy_prio=0, last_owner=AHB -> PHY granted N, ahb_stall=1 at N+1, write 0x05 issued N+1, conflict_cnt=1.
// - phy_prio=1, AHB read conflicts on 3 consecutive opportunities -> PHY wins all 3, each AHB read replayed, data valid 2 cycles after request, conflict_cnt=3.
// - Back-to-back conflicts phy_prio=0 -> grants alternate PHY/AHB, no requester waits >1 cycle.
// - Force conflict_cnt to 0xFFFF, one more conflict -> stays 0xFFFF.
// - Assert reset during REPLAY -> pending dropped, ahb_stall=0, mem_en=0 immediately; after release, first PHY request granted same cycle.

Source files
------------

// File: rtl/ble_buf_arbiter.sv
// Single-port packet buffer arbiter: one SRAM word access per cycle shared between
// the AHB data slicer and the PHY baseband, replaying AHB accesses that lose a conflict.
module ble_buf_arbiter #(
    parameter int AW    = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ahb_wr_en,
    input  logic             ahb_rd_en,
    input  logic [AW-1:0]    ahb_addr,
    input  logic [31:0]      ahb_wdata,
    output logic [31:0]      ahb_rdata,
    output logic             ahb_stall,
    input  logic             phy_req,
    input  logic             phy_we,
    input  logic [AW-1:0]    phy_addr,
    input  logic [31:0]      phy_wdata,
    input  logic             phy_prio,
    output logic             phy_gnt,
    output logic             phy_rvalid,
    output logic [31:0]      phy_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;
    localparam logic       OWN_AHB   = 1'b0;
    localparam logic       OWN_PHY   = 1'b1;
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_AHB   = 2'd1;
    localparam logic [1:0] SRC_PHY   = 2'd2;
    localparam logic [1:0] SRC_PEND  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic             pend_we_q, pend_we_d;
    logic [AW-1:0]    pend_addr_q, pend_addr_d;
    logic [31:0]      pend_wdata_q, pend_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ahb_ret_q, ahb_ret_d;
    logic             phy_ret_q, phy_ret_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       src;
    logic             ahb_req;
    logic             phy_req_v;

    // Requests are masked while reset is held so no SRAM access leaks out during reset.
    assign ahb_stall = (state_q == ST_REPLAY);
    assign ahb_req   = (ahb_wr_en | ahb_rd_en) & ~ahb_stall & reset;
    assign phy_req_v = phy_req & reset;

    always_comb begin
        src          = SRC_NONE;
        state_d      = state_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        cnt_d        = cnt_q;
        if (state_q == ST_REPLAY) begin
            src     = SRC_PEND;
            state_d = ST_RUN;
        end else if (ahb_req && phy_req_v) begin
            if (phy_prio || (last_owner_q == OWN_AHB)) begin
                src          = SRC_PHY;
                pend_we_d    = ahb_wr_en;
                pend_addr_d  = ahb_addr;
                pend_wdata_d = ahb_wdata;
                cnt_d        = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;
                state_d      = ST_REPLAY;
            end else begin
                src = SRC_AHB;
            end
        end else if (ahb_req) begin
            src = SRC_AHB;
        end else if (phy_req_v) begin
            src = SRC_PHY;
        end
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        phy_gnt      = 1'b0;
        ahb_ret_d    = 1'b0;
        phy_ret_d    = 1'b0;
        last_owner_d = last_owner_q;
        hold_d       = ahb_ret_q ? mem_rdata : hold_q;
        case (src)
            SRC_AHB: begin
                mem_en       = 1'b1;
                mem_we       = ahb_wr_en;
                mem_addr     = ahb_addr;
                mem_wdata    = ahb_wdata;
                ahb_ret_d    = ~ahb_wr_en;
                last_owner_d = OWN_AHB;
            end
            SRC_PHY: begin
                mem_en       = 1'b1;
                mem_we       = phy_we;
                mem_addr     = phy_addr;
                mem_wdata    = phy_wdata;
                phy_gnt      = 1'b1;
                phy_ret_d    = ~phy_we;
                last_owner_d = OWN_PHY;
            end
            SRC_PEND: begin
                mem_en       = 1'b1;
                mem_we       = pend_we_q;
                mem_addr     = pend_addr_q;
                mem_wdata    = pend_wdata_q;
                ahb_ret_d    = ~pend_we_q;
                last_owner_d = OWN_AHB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            last_owner_q <= OWN_AHB;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            cnt_q        <= '0;
            ahb_ret_q    <= 1'b0;
            phy_ret_q    <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            cnt_q        <= cnt_d;
            ahb_ret_q    <= ahb_ret_d;
            phy_ret_q    <= phy_ret_d;
            hold_q       <= hold_d;
        end
    end

    assign ahb_rdata    = ahb_ret_q ? mem_rdata : hold_q;
    assign phy_rvalid   = phy_ret_q;
    assign phy_rdata    = phy_ret_q ? mem_rdata : 32'h0;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_ble_buf_arbiter.sv
// Directed bench for ble_buf_arbiter with a behavioural 1-cycle-latency SRAM model
// and a narrow-counter second instance for the saturation boundary.
module tb_ble_buf_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ahb_wr_en, ahb_rd_en;
    logic [7:0]  ahb_addr;
    logic [31:0] ahb_wdata, ahb_rdata;
    logic        ahb_stall;
    logic        phy_req, phy_we, phy_prio;
    logic [7:0]  phy_addr;
    logic [31:0] phy_wdata, phy_rdata;
    logic        phy_gnt, phy_rvalid;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] conflict_cnt;

    logic [31:0] s_ahb_rdata, s_phy_rdata, s_mem_wdata;
    logic        s_ahb_stall, s_phy_gnt, s_phy_rvalid, s_mem_en, s_mem_we;
    logic [7:0]  s_mem_addr;
    logic [3:0]  s_conflict_cnt;

    logic [31:0] mem [0:255];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    ble_buf_arbiter #(.AW(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .ahb_wr_en(ahb_wr_en), .ahb_rd_en(ahb_rd_en), .ahb_addr(ahb_addr),
        .ahb_wdata(ahb_wdata), .ahb_rdata(ahb_rdata), .ahb_stall(ahb_stall),
        .phy_req(phy_req), .phy_we(phy_we), .phy_addr(phy_addr), .phy_wdata(phy_wdata),
        .phy_prio(phy_prio), .phy_gnt(phy_gnt), .phy_rvalid(phy_rvalid), .phy_rdata(phy_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    ble_buf_arbiter #(.AW(8), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .ahb_wr_en(ahb_wr_en), .ahb_rd_en(ahb_rd_en), .ahb_addr(ahb_addr),
        .ahb_wdata(ahb_wdata), .ahb_rdata(s_ahb_rdata), .ahb_stall(s_ahb_stall),
        .phy_req(phy_req), .phy_we(phy_we), .phy_addr(phy_addr), .phy_wdata(phy_wdata),
        .phy_prio(phy_prio), .phy_gnt(s_phy_gnt), .phy_rvalid(s_phy_rvalid), .phy_rdata(s_phy_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        ahb_wr_en = 1'b1; ahb_addr = a; ahb_wdata = d;
        tick();
        ahb_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; phy_req = 1'b1; ahb_rd_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en got %0b want 0", mem_en); end
        vectors++; if (phy_gnt !== 1'b0) begin miscompares++; $display("FAIL rst_phy_gnt got %0b want 0", phy_gnt); end
        vectors++; if (ahb_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0b want 0", ahb_stall); end
        vectors++; if (phy_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %0b want 0", phy_rvalid); end
        vectors++; if (conflict_cnt !== 16'h0) begin miscompares++; $display("FAIL rst_cnt got %h want 0000", conflict_cnt); end
        vectors++; if (ahb_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_ahb_rdata got %h want 0", ahb_rdata); end
        vectors++; if (phy_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_phy_rdata got %h want 0", phy_rdata); end
        phy_req = 1'b0; ahb_rd_en = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL idle_mem_en got %0b want 0", mem_en); end
        vectors++; if (mem_addr !== 8'h0) begin miscompares++; $display("FAIL idle_mem_addr got %h want 00", mem_addr); end
    endtask

    task automatic test_ahb_read();
        ahb_wr_en = 1'b1; ahb_addr = 8'h12; ahb_wdata = 32'hDEADBEEF;
        #1;
        vectors++; if ({mem_en, mem_we} !== 2'b11) begin miscompares++; $display("FAIL wr_en_we got %b want 11", {mem_en, mem_we}); end
        vectors++; if (mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_wdata got %h want deadbeef", mem_wdata); end
        tick();
        ahb_wr_en = 1'b0; ahb_rd_en = 1'b1; ahb_addr = 8'h12;
        #1;
        vectors++; if ({mem_en, mem_we} !== 2'b10) begin miscompares++; $display("FAIL rd_en_we got %b want 10", {mem_en, mem_we}); end
        vectors++; if (mem_addr !== 8'h12) begin miscompares++; $display("FAIL rd_addr got %h want 12", mem_addr); end
        vectors++; if (ahb_stall !== 1'b0) begin miscompares++; $display("FAIL rd_stall_n got %0b want 0", ahb_stall); end
        tick();
        ahb_rd_en = 1'b0;
        #1;
        vectors++; if (ahb_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data got %h want deadbeef", ahb_rdata); end
        vectors++; if (ahb_stall !== 1'b0) begin miscompares++; $display("FAIL rd_stall_n1 got %0b want 0", ahb_stall); end
        tick();
        vectors++; if (ahb_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hold got %h want deadbeef", ahb_rdata); end
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL rd_idle got %0b want 0", mem_en); end
    endtask

    task automatic test_conflict_prio0();
        ahb_write(8'h07, 32'h07070707);
        ahb_wr_en = 1'b1; ahb_addr = 8'h05; ahb_wdata = 32'h55AA55AA;
        phy_req = 1'b1; phy_we = 1'b0; phy_addr = 8'h07; phy_prio = 1'b0;
        #1;
        vectors++; if (phy_gnt !== 1'b1) begin miscompares++; $display("FAIL c0_phy_gnt got %0b want 1", phy_gnt); end
        vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h07}) begin miscompares++; $display("FAIL c0_mem got %b want 10_07", {mem_en, mem_we, mem_addr}); end
        vectors++; if (ahb_stall !== 1'b0) begin miscompares++; $display("FAIL c0_stall got %0b want 0", ahb_stall); end
        tick();
        phy_req = 1'b0; ahb_wdata = 32'hBAD0BAD0;
        #1;
        vectors++; if (ahb_stall !== 1'b1) begin miscompares++; $display("FAIL c1_stall got %0b want 1", ahb_stall); end
        vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 8'h05}) begin miscompares++; $display("FAIL c1_mem got %b want 11_05", {mem_en, mem_we, mem_addr}); end
        vectors++; if (mem_wdata !== 32'h55AA55AA) begin miscompares++; $display("FAIL c1_wdata got %h want 55aa55aa", mem_wdata); end
        vectors++; if (phy_gnt !== 1'b0) begin miscompares++; $display("FAIL c1_phy_gnt got %0b want 0", phy_gnt); end
        vectors++; if ({phy_rvalid, phy_rdata} !== {1'b1, 32'h07070707}) begin miscompares++; $display("FAIL c1_phy_rd got %b/%h want 1/07070707", phy_rvalid, phy_rdata); end
        vectors++; if (conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL c1_cnt got %0d want 1", conflict_cnt); end
        tick();
        ahb_wr_en = 1'b0;
        #1;
        vectors++; if ({ahb_stall, mem_en, phy_rvalid} !== 3'b000) begin miscompares++; $display("FAIL c2_quiet got %b want 000", {ahb_stall, mem_en, phy_rvalid}); end
        vectors++; if (phy_rdata !== 32'h0) begin miscompares++; $display("FAIL c2_phy_rdata got %h want 0", phy_rdata); end
        ahb_rd_en = 1'b1; ahb_addr = 8'h05;
        tick();
        ahb_rd_en = 1'b0;
        #1;
        vectors++; if (ahb_rdata !== 32'h55AA55AA) begin miscompares++; $display("FAIL c3_readback got %h want 55aa55aa", ahb_rdata); end
    endtask

    task automatic test_prio_replay();
        reset_pulse();
        for (int k = 0; k < 3; k++) ahb_write(8'h20 + 8'(k), 32'hA0000020 + 32'(k));
        phy_prio = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ahb_rd_en = 1'b1; ahb_addr = 8'h20 + 8'(k);
            phy_req = 1'b1; phy_we = 1'b1; phy_addr = 8'h30 + 8'(k); phy_wdata = 32'hB0000030 + 32'(k);
            #1;
            vectors++; if ({phy_gnt, mem_we, mem_addr} !== {2'b11, 8'h30 + 8'(k)}) begin miscompares++; $display("FAIL pr%0d_phy got %b want 11_%h", k, {phy_gnt, mem_we, mem_addr}, 8'h30 + 8'(k)); end
            tick();
            phy_req = 1'b0;
            #1;
            vectors++; if ({ahb_stall, phy_gnt, mem_we, mem_addr} !== {3'b100, 8'h20 + 8'(k)}) begin miscompares++; $display("FAIL pr%0d_replay got %b want 100_%h", k, {ahb_stall, phy_gnt, mem_we, mem_addr}, 8'h20 + 8'(k)); end
            tick();
            vectors++; if ({ahb_stall, ahb_rdata} !== {1'b0, 32'hA0000020 + 32'(k)}) begin miscompares++; $display("FAIL pr%0d_data got %b/%h want 0/%h", k, ahb_stall, ahb_rdata, 32'hA0000020 + 32'(k)); end
        end
        ahb_rd_en = 1'b0;
        vectors++; if (conflict_cnt !== 16'd3) begin miscompares++; $display("FAIL pr_cnt got %0d want 3", conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        reset_pulse();
        phy_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ahb_rd_en = 1'b1; ahb_addr = 8'h20 + 8'(i);
            phy_req = 1'b1; phy_we = 1'b0; phy_addr = 8'h30 + 8'(i);
            #1;
            vectors++; if ({phy_gnt, ahb_stall, mem_addr} !== {2'b10, 8'h30 + 8'(i)}) begin miscompares++; $display("FAIL bb%0d_phy got %b want 10_%h", i, {phy_gnt, ahb_stall, mem_addr}, 8'h30 + 8'(i)); end
            if (i > 0) begin
                vectors++; if (ahb_rdata !== 32'hA0000020 + 32'(i - 1)) begin miscompares++; $display("FAIL bb%0d_ahb_data got %h want %h", i, ahb_rdata, 32'hA0000020 + 32'(i - 1)); end
            end
            tick();
            phy_req = (i < 2); phy_addr = 8'h31 + 8'(i);
            #1;
            vectors++; if ({phy_gnt, ahb_stall, mem_addr} !== {2'b01, 8'h20 + 8'(i)}) begin miscompares++; $display("FAIL bb%0d_ahb got %b want 01_%h", i, {phy_gnt, ahb_stall, mem_addr}, 8'h20 + 8'(i)); end
            vectors++; if ({phy_rvalid, phy_rdata} !== {1'b1, 32'hB0000030 + 32'(i)}) begin miscompares++; $display("FAIL bb%0d_phy_data got %b/%h want 1/%h", i, phy_rvalid, phy_rdata, 32'hB0000030 + 32'(i)); end
            tick();
        end
        ahb_rd_en = 1'b0; phy_req = 1'b0;
        vectors++; if (ahb_rdata !== 32'hA0000022) begin miscompares++; $display("FAIL bb_last_data got %h want a0000022", ahb_rdata); end
        vectors++; if (conflict_cnt !== 16'd3) begin miscompares++; $display("FAIL bb_cnt got %0d want 3", conflict_cnt); end
        phy_req = 1'b1; phy_we = 1'b1; phy_addr = 8'h40; phy_wdata = 32'hC0000040;
        #1;
        vectors++; if (phy_gnt !== 1'b1) begin miscompares++; $display("FAIL rr_phy_only got %0b want 1", phy_gnt); end
        tick();
        ahb_wr_en = 1'b1; ahb_addr = 8'h41; ahb_wdata = 32'hD0000041;
        phy_we = 1'b0; phy_addr = 8'h20;
        #1;
        vectors++; if ({phy_gnt, ahb_stall, mem_we, mem_addr} !== {3'b001, 8'h41}) begin miscompares++; $display("FAIL rr_ahb_wins got %b want 001_41", {phy_gnt, ahb_stall, mem_we, mem_addr}); end
        tick();
        ahb_wr_en = 1'b0; ahb_rd_en = 1'b1;
        #1;
        vectors++; if ({phy_gnt, mem_addr} !== {1'b1, 8'h20}) begin miscompares++; $display("FAIL rr_phy_turn got %b want 1_20", {phy_gnt, mem_addr}); end
        tick();
        phy_req = 1'b0;
        #1;
        vectors++; if ({ahb_stall, mem_we, mem_addr} !== {2'b10, 8'h41}) begin miscompares++; $display("FAIL rr_replay got %b want 10_41", {ahb_stall, mem_we, mem_addr}); end
        vectors++; if (phy_rdata !== 32'hA0000020) begin miscompares++; $display("FAIL rr_phy_data got %h want a0000020", phy_rdata); end
        tick();
        ahb_rd_en = 1'b0;
        #1;
        vectors++; if (ahb_rdata !== 32'hD0000041) begin miscompares++; $display("FAIL rr_ahb_data got %h want d0000041", ahb_rdata); end
        vectors++; if (conflict_cnt !== 16'd4) begin miscompares++; $display("FAIL rr_cnt got %0d want 4", conflict_cnt); end
    endtask

    task automatic test_saturation();
        reset_pulse();
        phy_prio = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ahb_rd_en = 1'b1; ahb_addr = 8'h20;
            phy_req = 1'b1; phy_we = 1'b0; phy_addr = 8'h30;
            tick();
            phy_req = 1'b0;
            tick();
            if (i == 14) begin
                vectors++; if (s_conflict_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_reach got %h want f", s_conflict_cnt); end
            end
        end
        ahb_rd_en = 1'b0;
        vectors++; if (s_conflict_cnt !== 4'hF) begin miscompares++; $display("FAIL sat_hold got %h want f", s_conflict_cnt); end
        vectors++; if (conflict_cnt !== 16'd16) begin miscompares++; $display("FAIL sat_wide got %0d want 16", conflict_cnt); end
    endtask

    task automatic test_reset_replay();
        phy_prio = 1'b0;
        ahb_write(8'h50, 32'h11111111);
        ahb_wr_en = 1'b1; ahb_addr = 8'h50; ahb_wdata = 32'h99999999;
        phy_req = 1'b1; phy_we = 1'b0; phy_addr = 8'h30;
        tick();
        ahb_wr_en = 1'b0; phy_addr = 8'h12;
        #1;
        vectors++; if (ahb_stall !== 1'b1) begin miscompares++; $display("FAIL rr_in_replay got %0b want 1", ahb_stall); end
        reset = 1'b0;
        #1;
        vectors++; if ({ahb_stall, mem_en, phy_gnt} !== 3'b000) begin miscompares++; $display("FAIL rst_replay got %b want 000", {ahb_stall, mem_en, phy_gnt}); end
        vectors++; if (conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_replay_cnt got %0d want 0", conflict_cnt); end
        tick();
        reset = 1'b1;
        #1;
        vectors++; if ({phy_gnt, mem_en, mem_addr} !== {2'b11, 8'h12}) begin miscompares++; $display("FAIL post_rst_gnt got %b want 11_12", {phy_gnt, mem_en, mem_addr}); end
        tick();
        phy_req = 1'b0;
        #1;
        vectors++; if ({phy_rvalid, phy_rdata} !== {1'b1, 32'hDEADBEEF}) begin miscompares++; $display("FAIL post_rst_data got %b/%h want 1/deadbeef", phy_rvalid, phy_rdata); end
        ahb_rd_en = 1'b1; ahb_addr = 8'h50;
        tick();
        ahb_rd_en = 1'b0;
        #1;
        vectors++; if (ahb_rdata !== 32'h11111111) begin miscompares++; $display("FAIL dropped_write got %h want 11111111", ahb_rdata); end
    endtask

    initial begin
        reset = 1'b0;
        ahb_wr_en = 1'b0; ahb_rd_en = 1'b0; ahb_addr = 8'h0; ahb_wdata = 32'h0;
        phy_req = 1'b0; phy_we = 1'b0; phy_addr = 8'h0; phy_wdata = 32'h0; phy_prio = 1'b0;
        test_reset();
        test_ahb_read();
        test_conflict_prio0();
        test_prio_replay();
        test_back_to_back();
        test_saturation();
        test_reset_replay();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
